// File: rtl/dual_port_split_ram_if.sv
// Bus bundle for dual_port_split_ram: a data port and an instruction port,
// plus the ready/error status lines.
interface dual_port_split_ram_if #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 6,
    parameter int INST_WIDTH = 21
);
    logic                  Ram_Ready;
    logic                  Ram_Access_Err;
    logic                  Ram_Data_Read;
    logic                  Ram_Data_Write;
    logic [ADDR_WIDTH-1:0] Ram_Addr;
    logic [DATA_WIDTH-1:0] Ram_Data_In;
    logic [DATA_WIDTH-1:0] Ram_Data_Out;
    logic                  Ram_Data_Valid;
    logic                  Ram_Inst_Read;
    logic                  Ram_Inst_Write;
    logic [ADDR_WIDTH-1:0] Inst_Addr;
    logic [INST_WIDTH-1:0] Ram_Inst_In;
    logic [INST_WIDTH-1:0] Ram_Inst_Out;
    logic                  Ram_Inst_Valid;

    modport master (
        output Ram_Data_Read, Ram_Data_Write, Ram_Addr, Ram_Data_In,
        output Ram_Inst_Read, Ram_Inst_Write, Inst_Addr, Ram_Inst_In,
        input  Ram_Ready, Ram_Access_Err,
        input  Ram_Data_Out, Ram_Data_Valid, Ram_Inst_Out, Ram_Inst_Valid
    );

    modport slave (
        input  Ram_Data_Read, Ram_Data_Write, Ram_Addr, Ram_Data_In,
        input  Ram_Inst_Read, Ram_Inst_Write, Inst_Addr, Ram_Inst_In,
        output Ram_Ready, Ram_Access_Err,
        output Ram_Data_Out, Ram_Data_Valid, Ram_Inst_Out, Ram_Inst_Valid
    );
endinterface

// File: rtl/dual_port_split_ram.sv
// Split instruction/data word memory with independent data and instruction
// ports, registered reads, and an optional post-reset clear sequencer.
module dual_port_split_ram #(
    parameter int ADDR_WIDTH     = 6,
    parameter int DATA_WIDTH     = 6,
    parameter int INST_WIDTH     = 21,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic                   Clk,
    input  logic                   Rst,
    dual_port_split_ram_if.slave   bus
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic {CLEAR, RUN} state_t;

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_clear_addr;
    logic                  r_ready;
    logic                  r_err;
    logic [DATA_WIDTH-1:0] r_data_out;
    logic                  r_data_valid;
    logic [INST_WIDTH-1:0] r_inst_out;
    logic                  r_inst_valid;

    // The word's two fields never share a write, so they live in separate
    // arrays; each port then owns exactly one array.
    logic [DATA_WIDTH-1:0] r_mem_d [DEPTH];
    logic [INST_WIDTH-1:0] r_mem_i [DEPTH];

    logic w_any_req;
    logic w_clear_last;

    assign w_any_req    = bus.Ram_Data_Read | bus.Ram_Data_Write |
                          bus.Ram_Inst_Read | bus.Ram_Inst_Write;
    assign w_clear_last = (r_clear_addr == {ADDR_WIDTH{1'b1}});

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state      <= CLEAR_ON_RESET ? CLEAR : RUN;
            r_clear_addr <= '0;
            r_ready      <= 1'b0;
            r_err        <= 1'b0;
            r_data_out   <= '0;
            r_data_valid <= 1'b0;
            r_inst_out   <= '0;
            r_inst_valid <= 1'b0;
        end else begin
            r_err        <= 1'b0;
            r_data_out   <= '0;
            r_data_valid <= 1'b0;
            r_inst_out   <= '0;
            r_inst_valid <= 1'b0;
            case (r_state)
                CLEAR: begin
                    r_clear_addr <= r_clear_addr + ADDR_WIDTH'(1);
                    r_err        <= w_any_req;
                    if (w_clear_last) begin
                        r_state <= RUN;
                        r_ready <= 1'b1;
                    end
                end
                RUN: begin
                    r_ready <= 1'b1;
                    if (bus.Ram_Data_Read) begin
                        r_data_out   <= r_mem_d[bus.Ram_Addr];
                        r_data_valid <= 1'b1;
                    end
                    if (bus.Ram_Inst_Read) begin
                        r_inst_out   <= r_mem_i[bus.Inst_Addr];
                        r_inst_valid <= 1'b1;
                    end
                end
                default: r_state <= CLEAR;
            endcase
        end
    end

    // Array is never reset directly; reads above see pre-edge contents,
    // which gives read-first behaviour on a same-cycle read/write.
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            if (r_state == CLEAR) begin
                r_mem_d[r_clear_addr] <= '0;
                r_mem_i[r_clear_addr] <= '0;
            end else begin
                if (bus.Ram_Data_Write)
                    r_mem_d[bus.Ram_Addr] <= bus.Ram_Data_In;
                if (bus.Ram_Inst_Write)
                    r_mem_i[bus.Inst_Addr] <= bus.Ram_Inst_In;
            end
        end
    end

    assign bus.Ram_Ready      = r_ready;
    assign bus.Ram_Access_Err = r_err;
    assign bus.Ram_Data_Out   = r_data_out;
    assign bus.Ram_Data_Valid = r_data_valid;
    assign bus.Ram_Inst_Out   = r_inst_out;
    assign bus.Ram_Inst_Valid = r_inst_valid;
endmodule

// File: tb/tb_dual_port_split_ram.sv
// Bench for dual_port_split_ram: clear timing, access errors, read-first
// and field isolation, plus a CLEAR_ON_RESET=0 instance.
module tb_dual_port_split_ram;
    logic Clk = 1'b0;
    logic Rst = 1'b1;
    always #5 Clk = ~Clk;

    dual_port_split_ram_if b ();
    dual_port_split_ram_if b2 ();

    dual_port_split_ram u_dut (.Clk(Clk), .Rst(Rst), .bus(b));
    dual_port_split_ram #(.CLEAR_ON_RESET(1'b0)) u_dut2 (.Clk(Clk), .Rst(Rst), .bus(b2));

    typedef struct {
        logic        rd_d, wr_d;
        logic [5:0]  a, di;
        logic        rd_i, wr_i;
        logic [5:0]  ia;
        logic [20:0] ii;
        logic        dv;
        logic [5:0]  d;
        logic        iv;
        logic [20:0] i;
    } vec_t;

    typedef struct {
        logic        dv;
        logic [5:0]  d;
        logic        iv;
        logic [20:0] i;
    } exp_t;

    exp_t sb[$];
    vec_t vt[16];
    int   total = 0;
    int   bad   = 0;
    int   cnt;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic rd_d, wr_d, input logic [5:0] a, di,
                                input logic rd_i, wr_i, input logic [5:0] ia,
                                input logic [20:0] ii, input logic dv,
                                input logic [5:0] d, input logic iv,
                                input logic [20:0] i);
        vec_t v;
        v.rd_d = rd_d; v.wr_d = wr_d; v.a = a; v.di = di;
        v.rd_i = rd_i; v.wr_i = wr_i; v.ia = ia; v.ii = ii;
        v.dv = dv; v.d = d; v.iv = iv; v.i = i;
        return v;
    endfunction

    function automatic vec_t idle();
        return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endfunction

    task automatic step(input vec_t v);
        b.Ram_Data_Read  = v.rd_d;
        b.Ram_Data_Write = v.wr_d;
        b.Ram_Addr       = v.a;
        b.Ram_Data_In    = v.di;
        b.Ram_Inst_Read  = v.rd_i;
        b.Ram_Inst_Write = v.wr_i;
        b.Inst_Addr      = v.ia;
        b.Ram_Inst_In    = v.ii;
        @(posedge Clk);
        #1;
    endtask

    task automatic b2_drive(input logic rd, wr, input logic [5:0] a, di);
        b2.Ram_Data_Read  = rd;
        b2.Ram_Data_Write = wr;
        b2.Ram_Addr       = a;
        b2.Ram_Data_In    = di;
        b2.Ram_Inst_Read  = 1'b0;
        b2.Ram_Inst_Write = 1'b0;
        b2.Inst_Addr      = '0;
        b2.Ram_Inst_In    = '0;
    endtask

    initial begin
        exp_t e;
        vec_t v;
        // rd_d wr_d addr din rd_i wr_i iaddr iin | dv d iv i (after the edge)
        vt[0]  = mk(1, 0, 6'h3F, 0,     1, 0, 6'h3F, 0,        1, 6'h00, 1, 21'h0);
        vt[1]  = mk(0, 1, 6'h05, 6'h2A, 0, 0, 0,     0,        0, 6'h00, 0, 21'h0);
        vt[2]  = mk(1, 0, 6'h05, 0,     0, 0, 0,     0,        1, 6'h2A, 0, 21'h0);
        vt[3]  = idle();
        vt[4]  = mk(0, 1, 6'h09, 6'h11, 0, 1, 6'h09, 21'h1ABCDE, 0, 6'h00, 0, 21'h0);
        vt[5]  = mk(1, 0, 6'h09, 0,     1, 0, 6'h09, 0,        1, 6'h11, 1, 21'h1ABCDE);
        vt[6]  = mk(0, 1, 6'h07, 6'h03, 0, 0, 0,     0,        0, 6'h00, 0, 21'h0);
        vt[7]  = mk(1, 1, 6'h07, 6'h3C, 0, 0, 0,     0,        1, 6'h03, 0, 21'h0);
        vt[8]  = mk(1, 0, 6'h07, 0,     0, 0, 0,     0,        1, 6'h3C, 0, 21'h0);
        vt[9]  = mk(1, 0, 6'h07, 0,     1, 1, 6'h07, 21'h0F0F0, 1, 6'h3C, 1, 21'h0);
        vt[10] = mk(1, 0, 6'h09, 0,     1, 0, 6'h07, 0,        1, 6'h11, 1, 21'h0F0F0);
        vt[11] = mk(1, 0, 6'h05, 0,     0, 1, 6'h05, 21'h155555, 1, 6'h2A, 0, 21'h0);
        vt[12] = mk(1, 0, 6'h05, 0,     1, 0, 6'h05, 0,        1, 6'h2A, 1, 21'h155555);
        vt[13] = mk(1, 0, 6'h3F, 0,     1, 0, 6'h00, 0,        1, 6'h00, 1, 21'h0);
        vt[14] = mk(0, 1, 6'h3F, 6'h3F, 1, 0, 6'h09, 0,        0, 6'h00, 1, 21'h1ABCDE);
        vt[15] = mk(1, 0, 6'h3F, 0,     0, 0, 0,     0,        1, 6'h3F, 0, 21'h0);

        b2_drive(0, 0, 0, 0);
        Rst = 1'b1;
        step(idle());
        Rst = 1'b0;
        chk("rst_ready", 32'(b.Ram_Ready), 0);
        chk("rst_err", 32'(b.Ram_Access_Err), 0);
        chk("rst_dvalid", 32'(b.Ram_Data_Valid), 0);
        chk("rst_ivalid", 32'(b.Ram_Inst_Valid), 0);
        chk("rst_ready2", 32'(b2.Ram_Ready), 0);

        // Initial clear: count cycles to ready, with an illegal write at cycle 10
        cnt = 0;
        while (b.Ram_Ready !== 1'b1 && cnt < 200) begin
            v = idle();
            if (cnt == 9) v = mk(0, 1, 6'h00, 6'h3F, 0, 0, 0, 0, 0, 0, 0, 0);
            if (cnt == 1) b2_drive(0, 1, 6'h02, 6'h15);
            else if (cnt == 2) b2_drive(1, 0, 6'h02, 0);
            else b2_drive(0, 0, 0, 0);
            step(v);
            cnt++;
            if (cnt == 1) chk("noclr_ready_first_cycle", 32'(b2.Ram_Ready), 1);
            if (cnt == 3) begin
                chk("noclr_rd_valid", 32'(b2.Ram_Data_Valid), 1);
                chk("noclr_rd_data", 32'(b2.Ram_Data_Out), 32'h15);
            end
            if (cnt == 10) begin
                chk("clr_err_pulse", 32'(b.Ram_Access_Err), 1);
                chk("clr_no_valid", 32'(b.Ram_Data_Valid), 0);
            end
            if (cnt == 11) chk("clr_err_one_cycle", 32'(b.Ram_Access_Err), 0);
        end
        chk("clear_cycles", 32'(cnt), 64);

        // Table vectors through the scoreboard
        for (int k = 0; k < 16; k++) begin
            e.dv = vt[k].dv; e.d = vt[k].d; e.iv = vt[k].iv; e.i = vt[k].i;
            sb.push_back(e);
            step(vt[k]);
            e = sb.pop_front();
            chk($sformatf("v%0d_dvalid", k), 32'(b.Ram_Data_Valid), 32'(e.dv));
            chk($sformatf("v%0d_dout", k), 32'(b.Ram_Data_Out), 32'(e.d));
            chk($sformatf("v%0d_ivalid", k), 32'(b.Ram_Inst_Valid), 32'(e.iv));
            chk($sformatf("v%0d_iout", k), 32'(b.Ram_Inst_Out), 32'(e.i));
            chk($sformatf("v%0d_err", k), 32'(b.Ram_Access_Err), 0);
        end

        // Write during clear at addr 0 must have been dropped
        step(mk(1, 0, 6'h00, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        chk("clr_write_ignored", 32'(b.Ram_Data_Out), 0);

        // Reset in RUN, then again at clear cycle 30
        Rst = 1'b1;
        step(idle());
        Rst = 1'b0;
        chk("rerun_ready_low", 32'(b.Ram_Ready), 0);
        for (int k = 0; k < 30; k++) step(idle());
        chk("midclr_ready_low", 32'(b.Ram_Ready), 0);
        Rst = 1'b1;
        step(idle());
        Rst = 1'b0;
        cnt = 0;
        while (b.Ram_Ready !== 1'b1 && cnt < 200) begin
            step(idle());
            cnt++;
        end
        chk("midclr_restart_cycles", 32'(cnt), 64);
        step(mk(1, 0, 6'h05, 0, 1, 0, 6'h09, 0, 0, 0, 0, 0));
        chk("recleared_data", 32'(b.Ram_Data_Out), 0);
        chk("recleared_inst", 32'(b.Ram_Inst_Out), 0);
        chk("recleared_valid", 32'(b.Ram_Data_Valid), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
